// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the pipelined RISC-V control path: opcodes, mux selects,
// ALU operations and the decoded control bundle carried into EX.
package riscv_ctrl_pkg;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  typedef enum logic [2:0] {
    ImmI = 3'b000,
    ImmS = 3'b001,
    ImmB = 3'b010,
    ImmJ = 3'b011,
    ImmU = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    ResAlu = 2'b00,
    ResMem = 2'b01,
    ResPc4 = 2'b10,
    ResImm = 2'b11
  } result_src_e;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluSlt  = 4'd5,
    AluSltu = 4'd6,
    AluSll  = 4'd7,
    AluSrl  = 4'd8,
    AluSra  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    alu_op_e     alu_op;
    logic        alu_src;
    logic        pc_tgt_src;
    logic [2:0]  funct3;
  } ctrl_t;

  localparam ctrl_t CtrlNop = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational main decoder plus ALU decoder; unsupported encodings flag illegal
// and leave every control field at NOP.
module ctrl_decode
  import riscv_ctrl_pkg::*;
#(
  parameter bit EN_FULL_BRANCH = 1'b1,
  parameter bit EN_JALR        = 1'b1
) (
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output imm_src_e   imm_src_o,
  output logic       illegal_o,
  output ctrl_t      ctrl_o
);

  alu_op_e alu_funct;

  // Shared by R-type and I-type; funct7b5 picks sra for both.
  always_comb begin
    case (funct3_i)
      3'b000:  alu_funct = AluAdd;
      3'b001:  alu_funct = AluSll;
      3'b010:  alu_funct = AluSlt;
      3'b011:  alu_funct = AluSltu;
      3'b100:  alu_funct = AluXor;
      3'b101:  alu_funct = funct7b5_i ? AluSra : AluSrl;
      3'b110:  alu_funct = AluOr;
      default: alu_funct = AluAnd;
    endcase
  end

  always_comb begin
    ctrl_o    = CtrlNop;
    imm_src_o = ImmI;
    illegal_o = 1'b0;
    case (op_i)
      OpLoad: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.result_src = ResMem;
      end
      OpStore: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        imm_src_o        = ImmS;
      end
      OpRtype: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = (funct3_i == 3'b000 && funct7b5_i) ? AluSub : alu_funct;
      end
      OpItype: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = alu_funct;
      end
      OpBranch: begin
        if (funct3_i == 3'b010 || funct3_i == 3'b011 ||
            (!EN_FULL_BRANCH && funct3_i != F3Beq)) begin
          illegal_o = 1'b1;
        end else begin
          ctrl_o.branch = 1'b1;
          ctrl_o.alu_op = AluSub;
          ctrl_o.funct3 = funct3_i;
          imm_src_o     = ImmB;
        end
      end
      OpJal: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.jump       = 1'b1;
        ctrl_o.result_src = ResPc4;
        imm_src_o         = ImmJ;
      end
      OpLui: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.result_src = ResImm;
        imm_src_o         = ImmU;
      end
      OpJalr: begin
        if (!EN_JALR) begin
          illegal_o = 1'b1;
        end else begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.alu_src    = 1'b1;
          ctrl_o.jump       = 1'b1;
          ctrl_o.pc_tgt_src = 1'b1;
          ctrl_o.result_src = ResPc4;
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_controller.sv
// Pipelined control unit: decode in D, ID/EX/MEM/WB control registers and
// branch resolution in EX.
module pipe_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W      = 4,
  parameter bit          EN_FULL_BRANCH = 1'b1,
  parameter bit          EN_JALR        = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opD,
  input  logic [2:0]           funct3D,
  input  logic                 funct7b5D,
  input  logic                 FlushE,
  input  logic                 ZeroE,
  input  logic                 LtE,
  input  logic                 LtuE,
  output logic [2:0]           ImmSrcD,
  output logic                 IllegalD,
  output logic                 ALUSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 PCSrcE,
  output logic                 PCTgtSrcE,
  output logic [1:0]           ResultSrcE,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic [1:0]           ResultSrcM,
  output logic                 RegWriteW,
  output logic [1:0]           ResultSrcW
);

  if (ALUCTRL_W < 4) begin : g_bad_width
    $error("pipe_controller: ALUCTRL_W must be at least 4");
  end

  imm_src_e   imm_src_d;
  ctrl_t      ctrl_d;
  ctrl_t      ctrl_e_q;
  logic       reg_write_m_q, mem_write_m_q, reg_write_w_q;
  logic [1:0] result_src_m_q, result_src_w_q;
  logic       taken_e;

  ctrl_decode #(
    .EN_FULL_BRANCH(EN_FULL_BRANCH),
    .EN_JALR       (EN_JALR)
  ) u_decode (
    .op_i      (opD),
    .funct3_i  (funct3D),
    .funct7b5_i(funct7b5D),
    .imm_src_o (imm_src_d),
    .illegal_o (IllegalD),
    .ctrl_o    (ctrl_d)
  );

  // Reset outranks flush; both turn the EX slot into a bubble.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      ctrl_e_q <= CtrlNop;
    end else begin
      ctrl_e_q <= ctrl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      result_src_m_q <= 2'b00;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= 2'b00;
    end else begin
      reg_write_m_q  <= ctrl_e_q.reg_write;
      mem_write_m_q  <= ctrl_e_q.mem_write;
      result_src_m_q <= ctrl_e_q.result_src;
      reg_write_w_q  <= reg_write_m_q;
      result_src_w_q <= result_src_m_q;
    end
  end

  always_comb begin
    taken_e = 1'b0;
    case (ctrl_e_q.funct3)
      F3Beq:   taken_e = ZeroE;
      F3Bne:   taken_e = ~ZeroE;
      F3Blt:   taken_e = LtE;
      F3Bge:   taken_e = ~LtE;
      F3Bltu:  taken_e = LtuE;
      F3Bgeu:  taken_e = ~LtuE;
      default: taken_e = 1'b0;
    endcase
  end

  always_comb begin
    ALUControlE      = '0;
    ALUControlE[3:0] = ctrl_e_q.alu_op;
  end

  assign ImmSrcD    = imm_src_d;
  assign ALUSrcE    = ctrl_e_q.alu_src;
  assign PCSrcE     = (ctrl_e_q.branch & taken_e) | ctrl_e_q.jump;
  assign PCTgtSrcE  = ctrl_e_q.pc_tgt_src;
  assign ResultSrcE = ctrl_e_q.result_src;
  assign RegWriteM  = reg_write_m_q;
  assign MemWriteM  = mem_write_m_q;
  assign ResultSrcM = result_src_m_q;
  assign RegWriteW  = reg_write_w_q;
  assign ResultSrcW = result_src_w_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Scoreboard bench: stimulus pushes model expectations for two configurations,
// a monitor pops and compares them once per cycle.
module tb_pipe_controller;

  typedef struct packed {
    logic [2:0] imm;
    logic       ill;
    logic       alusrc;
    logic [3:0] alu;
    logic       rw;
    logic       mw;
    logic [1:0] rs;
    logic       br;
    logic       jmp;
    logic       tgt;
    logic [2:0] f3;
  } mctl_t;

  typedef struct packed {
    int         cyc;
    logic [2:0] imm0;
    logic       ill0;
    logic       alusrc;
    logic [3:0] alu;
    logic       pcsrc;
    logic       tgt;
    logic [1:0] rs_e;
    logic       rw_m;
    logic       mw_m;
    logic [1:0] rs_m;
    logic       rw_w;
    logic [1:0] rs_w;
    logic [2:0] imm1;
    logic       ill1;
    logic       pcsrc1;
    logic       rw_w1;
  } exp_t;

  // add sll slt sltu xor srl or and, indexed by funct3
  localparam logic [3:0] ALU_TAB [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
  localparam logic [6:0] OPS [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                     7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

  logic clk = 1'b0;
  logic reset, FlushE, ZeroE, LtE, LtuE, funct7b5D;
  logic [6:0] opD;
  logic [2:0] funct3D;

  logic [2:0] imm0, imm1;
  logic ill0, ill1, alusrc0, alusrc1, pcsrc0, pcsrc1, tgt0, tgt1;
  logic [3:0] alu0, alu1;
  logic [1:0] rse0, rse1, rsm0, rsm1, rsw0, rsw1;
  logic rwm0, rwm1, mwm0, mwm1, rww0, rww1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit first = 1'b1;
  exp_t sbq[$];
  mctl_t st_e [2];
  mctl_t st_m [2];
  mctl_t st_w [2];

  always #5 clk = ~clk;

  pipe_controller dut0 (
    .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
    .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
    .ImmSrcD(imm0), .IllegalD(ill0), .ALUSrcE(alusrc0), .ALUControlE(alu0),
    .PCSrcE(pcsrc0), .PCTgtSrcE(tgt0), .ResultSrcE(rse0), .RegWriteM(rwm0),
    .MemWriteM(mwm0), .ResultSrcM(rsm0), .RegWriteW(rww0), .ResultSrcW(rsw0)
  );

  pipe_controller #(
    .ALUCTRL_W(4), .EN_FULL_BRANCH(1'b0), .EN_JALR(1'b0)
  ) dut1 (
    .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
    .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
    .ImmSrcD(imm1), .IllegalD(ill1), .ALUSrcE(alusrc1), .ALUControlE(alu1),
    .PCSrcE(pcsrc1), .PCTgtSrcE(tgt1), .ResultSrcE(rse1), .RegWriteM(rwm1),
    .MemWriteM(mwm1), .ResultSrcM(rsm1), .RegWriteW(rww1), .ResultSrcW(rsw1)
  );

  function automatic mctl_t model_dec(logic [6:0] op, logic [2:0] f3, logic f7, bit full,
                                      bit jalr_en);
    mctl_t c;
    bit legal;
    c = '0;
    legal = 1'b1;
    case (op)
      7'b0110011: begin
        c.rw  = 1'b1;
        c.alu = ALU_TAB[f3];
        if (f7 && f3 == 3'd0) c.alu = 4'd1;
        if (f7 && f3 == 3'd5) c.alu = 4'd9;
      end
      7'b0010011: begin
        c.rw = 1'b1; c.alusrc = 1'b1;
        c.alu = (f7 && f3 == 3'd5) ? 4'd9 : ALU_TAB[f3];
      end
      7'b0000011: begin c.rw = 1'b1; c.alusrc = 1'b1; c.rs = 2'd1; end
      7'b0100011: begin c.mw = 1'b1; c.alusrc = 1'b1; c.imm = 3'd1; end
      7'b1100011: begin
        legal = !(f3 == 3'd2 || f3 == 3'd3) && (full || f3 == 3'd0);
        c.br = 1'b1; c.imm = 3'd2; c.alu = 4'd1; c.f3 = f3;
      end
      7'b1101111: begin c.rw = 1'b1; c.imm = 3'd3; c.rs = 2'd2; c.jmp = 1'b1; end
      7'b0110111: begin c.rw = 1'b1; c.imm = 3'd4; c.rs = 2'd3; end
      7'b1100111: begin
        legal = jalr_en;
        c.rw = 1'b1; c.alusrc = 1'b1; c.rs = 2'd2; c.jmp = 1'b1; c.tgt = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      c = '0;
      c.ill = 1'b1;
    end
    return c;
  endfunction

  function automatic logic model_taken(logic [2:0] f3, logic z, logic lt, logic ltu);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input int c, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic fl, input logic rst, input logic z, input logic lt,
                       input logic ltu);
    exp_t x;
    mctl_t dec [2];
    opD = op; funct3D = f3; funct7b5D = f7; FlushE = fl; reset = rst;
    ZeroE = z; LtE = lt; LtuE = ltu;
    for (int k = 0; k < 2; k++) dec[k] = model_dec(op, f3, f7, k == 0, k == 0);
    if (!first) begin
      x.cyc    = cyc;
      x.imm0   = dec[0].imm;
      x.ill0   = dec[0].ill;
      x.alusrc = st_e[0].alusrc;
      x.alu    = st_e[0].alu;
      x.pcsrc  = (st_e[0].br && model_taken(st_e[0].f3, z, lt, ltu)) || st_e[0].jmp;
      x.tgt    = st_e[0].tgt;
      x.rs_e   = st_e[0].rs;
      x.rw_m   = st_m[0].rw;
      x.mw_m   = st_m[0].mw;
      x.rs_m   = st_m[0].rs;
      x.rw_w   = st_w[0].rw;
      x.rs_w   = st_w[0].rs;
      x.imm1   = dec[1].imm;
      x.ill1   = dec[1].ill;
      x.pcsrc1 = (st_e[1].br && model_taken(st_e[1].f3, z, lt, ltu)) || st_e[1].jmp;
      x.rw_w1  = st_w[1].rw;
      sbq.push_back(x);
    end
    first = 1'b0;
    for (int k = 0; k < 2; k++) begin
      st_w[k] = rst ? '0 : st_m[k];
      st_m[k] = rst ? '0 : st_e[k];
      st_e[k] = (rst || fl) ? '0 : dec[k];
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        chk("ImmSrcD", x.cyc, imm0, x.imm0);
        chk("IllegalD", x.cyc, ill0, x.ill0);
        chk("ALUSrcE", x.cyc, alusrc0, x.alusrc);
        chk("ALUControlE", x.cyc, alu0, x.alu);
        chk("PCSrcE", x.cyc, pcsrc0, x.pcsrc);
        chk("PCTgtSrcE", x.cyc, tgt0, x.tgt);
        chk("ResultSrcE", x.cyc, rse0, x.rs_e);
        chk("RegWriteM", x.cyc, rwm0, x.rw_m);
        chk("MemWriteM", x.cyc, mwm0, x.mw_m);
        chk("ResultSrcM", x.cyc, rsm0, x.rs_m);
        chk("RegWriteW", x.cyc, rww0, x.rw_w);
        chk("ResultSrcW", x.cyc, rsw0, x.rs_w);
        chk("ImmSrcD_lite", x.cyc, imm1, x.imm1);
        chk("IllegalD_lite", x.cyc, ill1, x.ill1);
        chk("PCSrcE_lite", x.cyc, pcsrc1, x.pcsrc1);
        chk("RegWriteW_lite", x.cyc, rww1, x.rw_w1);
      end
    end
  end

  initial begin : stimulus
    int unsigned r;
    logic [6:0] op;
    int wait_cycles;
    for (int k = 0; k < 2; k++) begin
      st_e[k] = '0; st_m[k] = '0; st_w[k] = '0;
    end
    // op, funct3, funct7b5, flush, reset, zero, lt, ltu
    drive(7'b0000000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(7'b0110011, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(7'b1100011, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(7'b1100011, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(7'b1100011, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(7'b1101111, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(7'b1111111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    drive(7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(7'b1101111, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(7'b0110011, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(7'b0010011, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(7'b0010011, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(7'b0110111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(7'b1100011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      op = (r < 88) ? OPS[r % 8] : 7'($urandom);
      drive(op, 3'($urandom), 1'($urandom), ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 4), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    wait_cycles = 0;
    while (sbq.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    #3;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
